// File: rtl/nibble_frame_tx.sv
// Nibble frame transmitter: queues whole frames in a small FIFO and sends each
// one as NBEAT req-qualified beats, LSB beat first, with a forced idle gap between frames.
module nibble_frame_tx #(
  parameter int DW    = 4,
  parameter int NBEAT = 4,
  parameter int DEPTH = 2,
  parameter int GAP   = 2
) (
  input  logic                      clk_2,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DW*NBEAT-1:0]       in_frame,
  input  logic                      hold,
  output logic                      req,
  output logic [DW-1:0]             data,
  output logic                      frame_start,
  output logic                      frame_end,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(NBEAT);
  localparam int FW = DW * NBEAT;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

  state_t          state, state_next;
  logic [BW-1:0]   beat, beat_next;
  logic [3:0]      gap_cnt, gap_next;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [FW-1:0]   mem [DEPTH];
  logic [FW-1:0]   head;
  logic            push, pop, last_beat;

  assign in_ready  = (level < LW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign last_beat = (beat == BW'(NBEAT - 1));
  assign pop       = (state == ST_SEND) && !hold && last_beat;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      beat    <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_next;
      beat    <= beat_next;
      gap_cnt <= gap_next;
    end
  end

  // The gap decision looks at level after the pop, which is already registered while in ST_GAP.
  always_comb begin
    state_next = state;
    beat_next  = beat;
    gap_next   = gap_cnt;
    case (state)
      ST_IDLE: begin
        if (level != '0) begin
          state_next = ST_SEND;
          beat_next  = '0;
        end
      end
      ST_SEND: begin
        if (!hold) begin
          if (last_beat) begin
            state_next = ST_GAP;
            beat_next  = '0;
            gap_next   = 4'(GAP);
          end else begin
            beat_next = beat + BW'(1);
          end
        end
      end
      ST_GAP: begin
        gap_next = gap_cnt - 4'd1;
        if (gap_cnt == 4'd1) begin
          state_next = (level != '0) ? ST_SEND : ST_IDLE;
          beat_next  = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        beat_next  = '0;
        gap_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Payload storage needs no reset; the cleared pointers and level make old entries unreachable.
  always_ff @(posedge clk_2) begin
    if (push) mem[wr_ptr] <= in_frame;
  end

  always_comb begin
    req         = (state == ST_SEND) && !hold;
    data        = req ? head[beat*DW +: DW] : '0;
    frame_start = req && (beat == '0);
    frame_end   = req && last_beat;
    busy        = (state != ST_IDLE) || (level != '0);
  end

endmodule
